// File: rtl/axis_downsizer_if.sv
// Minimal AXI Stream bundle (tvalid/tready/tdata) with subordinate and manager views.
interface axis_downsizer_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport s (input tvalid, input tdata, output tready);
  modport m (output tvalid, output tdata, input tready);
endinterface

// File: rtl/axis_downsizer.sv
// Wide-to-narrow AXI Stream serializer: one wide word becomes RATIO narrow beats,
// least-significant slice first, with m_last flagging the final beat of each word.
module axis_downsizer #(
  parameter int RATIO = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  axis_downsizer_if.s  axis_sif,
  axis_downsizer_if.m  axis_mif,
  output logic         m_last,
  input  logic         flush
);

  localparam int NW = axis_mif.TDATA_WIDTH;
  localparam int WW = axis_sif.TDATA_WIDTH;
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  generate
    if (RATIO < 2 || WW != RATIO * NW) begin : g_cfg_err
      $fatal(1, "axis_downsizer: wide width must equal RATIO * narrow width, RATIO >= 2");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wdata_q, wdata_d;

  logic busy;
  logic last_beat;
  logic s_ready;
  logic s_hs;
  logic m_hs;

  assign busy      = (state_q == SEND);
  assign last_beat = busy && (cnt_q == LAST_CNT);
  // A new word may enter only when idle or when the last beat leaves this very cycle.
  assign s_ready   = !flush && (!busy || (last_beat && axis_mif.tready));
  assign s_hs      = axis_sif.tvalid && s_ready;
  assign m_hs      = busy && axis_mif.tready;

  assign axis_sif.tready = s_ready;
  assign axis_mif.tvalid = busy;
  assign axis_mif.tdata  = wdata_q[NW * int'(cnt_q) +: NW];
  assign m_last          = last_beat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_hs) begin
            wdata_d = axis_sif.tdata;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (m_hs) begin
            if (last_beat) begin
              cnt_d = '0;
              if (s_hs) begin
                wdata_d = axis_sif.tdata;
                state_d = SEND;
              end else begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  // A stalled beat must stay put until taken (flush is the only way to drop it).
  a_m_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (axis_mif.tvalid && !axis_mif.tready && !flush) |=> (axis_mif.tvalid && $stable(axis_mif.tdata)));

  a_no_early_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (busy && !last_beat) |-> !axis_sif.tready);

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer: RATIO=4 (32->8) plus a RATIO=3 (24->8) instance.
module tb_axis_downsizer;

  logic clk;
  logic rst_n;
  logic flush4, flush3;
  logic last4, last3;

  axis_downsizer_if #(.TDATA_WIDTH(32)) s4 ();
  axis_downsizer_if #(.TDATA_WIDTH(8))  m4 ();
  axis_downsizer_if #(.TDATA_WIDTH(24)) s3 ();
  axis_downsizer_if #(.TDATA_WIDTH(8))  m3 ();

  axis_downsizer #(.RATIO(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .axis_sif (s4),
    .axis_mif (m4),
    .m_last   (last4),
    .flush    (flush4)
  );

  axis_downsizer #(.RATIO(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .axis_sif (s3),
    .axis_mif (m3),
    .m_last   (last3),
    .flush    (flush3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] word;
  logic [8:0]  sb[$];
  logic [8:0]  e;
  logic        acc;
  int          sent;
  int          cyc;

  initial begin
    rst_n  = 1'b0;
    flush4 = 1'b0;
    flush3 = 1'b0;
    s4.tvalid = 1'b0; s4.tdata = '0; m4.tready = 1'b0;
    s3.tvalid = 1'b0; s3.tdata = '0; m3.tready = 1'b0;

    // Reset state
    #12;
    chk("rst_m_tvalid", m4.tvalid, 0);
    chk("rst_m_tdata", m4.tdata, 0);
    chk("rst_m_last", last4, 0);
    chk("rst_s_tready", s4.tready, 1);
    chk("rst3_m_tvalid", m3.tvalid, 0);
    chk("rst3_s_tready", s3.tready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, consumer always ready
    @(negedge clk);
    s4.tvalid = 1'b1; s4.tdata = 32'hDDCCBBAA; m4.tready = 1'b1;
    #1;
    chk("t1_accept_ready", s4.tready, 1);
    chk("t1_idle_tvalid", m4.tvalid, 0);
    word = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s4.tvalid = 1'b0;
      #1;
      chk("t1_tvalid", m4.tvalid, 1);
      chk("t1_tdata", m4.tdata, word[8*i +: 8]);
      chk("t1_last", last4, (i == 3));
    end
    @(negedge clk);
    #1;
    chk("t1_done_tvalid", m4.tvalid, 0);
    chk("t1_done_last", last4, 0);

    // Two words back to back: no bubble, second accepted with beat 03
    @(negedge clk);
    s4.tvalid = 1'b1; s4.tdata = 32'h03020100;
    #1;
    chk("t2_accept0", s4.tready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s4.tvalid = (i < 4);
      s4.tdata  = 32'h07060504;
      #1;
      chk("t2_tvalid", m4.tvalid, 1);
      chk("t2_tdata", m4.tdata, i);
      chk("t2_last", last4, (i % 4 == 3));
      chk("t2_s_tready", s4.tready, (i % 4 == 3));
    end
    @(negedge clk);
    s4.tvalid = 1'b0;
    #1;
    chk("t2_done_tvalid", m4.tvalid, 0);

    // Flush after beat BB
    @(negedge clk);
    s4.tvalid = 1'b1; s4.tdata = 32'hDDCCBBAA;
    #1;
    @(negedge clk);
    s4.tvalid = 1'b0;
    #1;
    chk("fl_beat_aa", m4.tdata, 8'hAA);
    @(negedge clk);
    #1;
    chk("fl_beat_bb", m4.tdata, 8'hBB);
    @(negedge clk);
    flush4 = 1'b1;
    #1;
    chk("fl_s_tready_low", s4.tready, 0);
    chk("fl_beat_cc_shown", m4.tdata, 8'hCC);
    @(negedge clk);
    flush4 = 1'b0;
    s4.tvalid = 1'b1; s4.tdata = 32'h44332211;
    #1;
    chk("fl_after_tvalid", m4.tvalid, 0);
    chk("fl_after_s_tready", s4.tready, 1);
    word = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s4.tvalid = 1'b0;
      #1;
      chk("fl_next_tvalid", m4.tvalid, 1);
      chk("fl_next_tdata", m4.tdata, word[8*i +: 8]);
      chk("fl_next_last", last4, (i == 3));
    end
    @(negedge clk);
    #1;
    chk("fl_done_tvalid", m4.tvalid, 0);

    // Reset mid-word after beat AA, then a full word with a stall on beat 66
    @(negedge clk);
    s4.tvalid = 1'b1; s4.tdata = 32'hDDCCBBAA;
    #1;
    @(negedge clk);
    s4.tvalid = 1'b0;
    #1;
    chk("rw_beat_aa", m4.tdata, 8'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_tvalid_low", m4.tvalid, 0);
    chk("rw_last_low", last4, 0);
    chk("rw_tdata_zero", m4.tdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s4.tvalid = 1'b1; s4.tdata = 32'h88776655;
    #1;
    chk("rw_s_tready", s4.tready, 1);
    chk("rw_idle_tvalid", m4.tvalid, 0);
    @(negedge clk);
    s4.tvalid = 1'b0;
    #1;
    chk("rw_beat_55", m4.tdata, 8'h55);
    @(negedge clk);
    m4.tready = 1'b0;
    #1;
    chk("rw_stall1_tdata", m4.tdata, 8'h66);
    chk("rw_stall1_s_tready", s4.tready, 0);
    @(negedge clk);
    #1;
    chk("rw_stall2_tvalid", m4.tvalid, 1);
    chk("rw_stall2_tdata", m4.tdata, 8'h66);
    @(negedge clk);
    m4.tready = 1'b1;
    #1;
    chk("rw_beat_66", m4.tdata, 8'h66);
    @(negedge clk);
    #1;
    chk("rw_beat_77", m4.tdata, 8'h77);
    @(negedge clk);
    #1;
    chk("rw_beat_88", m4.tdata, 8'h88);
    chk("rw_last_88", last4, 1);
    @(negedge clk);
    #1;
    chk("rw_done_tvalid", m4.tvalid, 0);

    // Random words with random backpressure against an LSB-first scoreboard
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    word = $urandom;
    s4.tvalid = 1'b0;
    while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        s4.tvalid = 1'b0;
        word = $urandom;
      end
      acc = 1'b0;
      if (!s4.tvalid && sent < 1000) s4.tvalid = ($urandom_range(0, 3) != 0);
      s4.tdata  = s4.tvalid ? word : $urandom;
      m4.tready = 1'($urandom_range(0, 1));
      #1;
      if (m4.tvalid && m4.tready) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious_beat", m4.tvalid, 0);
        end else begin
          e = sb.pop_front();
          chk("rnd_tdata", m4.tdata, e[7:0]);
          chk("rnd_last", last4, e[8]);
        end
      end
      if (s4.tvalid && s4.tready) begin
        for (int k = 0; k < 4; k++) sb.push_back({(k == 3), word[8*k +: 8]});
        sent++;
        acc = 1'b1;
      end
    end
    chk("rnd_words_sent", sent, 1000);
    chk("rnd_drained", sb.size(), 0);
    @(negedge clk);
    s4.tvalid = 1'b0;
    m4.tready = 1'b1;
    #1;
    chk("rnd_idle_tvalid", m4.tvalid, 0);

    // RATIO=3: two words back to back, counter wraps after beat 2
    @(negedge clk);
    s3.tvalid = 1'b1; s3.tdata = 24'h332211; m3.tready = 1'b1;
    #1;
    chk("r3_accept0", s3.tready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s3.tvalid = (i < 3);
      s3.tdata  = 24'h665544;
      #1;
      chk("r3_tvalid", m3.tvalid, 1);
      chk("r3_tdata", m3.tdata, 8'(8'h11 * (i + 1)));
      chk("r3_last", last3, (i % 3 == 2));
      chk("r3_s_tready", s3.tready, (i % 3 == 2));
    end
    @(negedge clk);
    s3.tvalid = 1'b0;
    #1;
    chk("r3_done_tvalid", m3.tvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
